// File: rtl/rob_multi_commit_if.sv
// Dispatcher/CDB/commit/LSB/fetch bundle of the multi-commit reorder buffer.
// Query ports exist only when ROB_OPERAND_QUERY_EN is defined.
interface rob_multi_commit_if #(
  parameter int ROB_WIDTH    = 3,
  parameter int COMMIT_WIDTH = 2,
  parameter int CDB_PORTS    = 2
);
  logic                             alloc_valid;
  logic                             alloc_ready;
  logic [ROB_WIDTH-1:0]             alloc_index;
  logic [2:0]                       alloc_type;
  logic [4:0]                       alloc_rd;
  logic [31:0]                      alloc_pc;
  logic                             alloc_pred_taken;
  logic [31:0]                      alloc_alt_pc;

  logic [CDB_PORTS-1:0]             cdb_valid;
  logic [CDB_PORTS*ROB_WIDTH-1:0]   cdb_index;
  logic [CDB_PORTS*32-1:0]          cdb_data;

  logic [COMMIT_WIDTH-1:0]          commit_valid;
  logic [COMMIT_WIDTH*5-1:0]        commit_rd;
  logic [COMMIT_WIDTH*ROB_WIDTH-1:0] commit_index;
  logic [COMMIT_WIDTH*32-1:0]       commit_data;

  logic                             store_commit_valid;
  logic [ROB_WIDTH-1:0]             store_commit_index;
  logic                             store_commit_ready;

  logic                             redirect_en;
  logic [31:0]                      redirect_pc;
  logic                             bp_update_en;
  logic [31:0]                      bp_update_pc;
  logic                             bp_update_taken;
  logic                             flush_out;
  logic [ROB_WIDTH:0]               count;

`ifdef ROB_OPERAND_QUERY_EN
  logic [1:0][ROB_WIDTH-1:0]        q_index;
  logic [1:0]                       q_ready;
  logic [1:0][31:0]                 q_data;
`endif

  // The ROB serves requests, so it takes the slave view.
  modport slave (
    input  alloc_valid, alloc_type, alloc_rd, alloc_pc, alloc_pred_taken, alloc_alt_pc,
    output alloc_ready, alloc_index,
    input  cdb_valid, cdb_index, cdb_data,
    output commit_valid, commit_rd, commit_index, commit_data,
    output store_commit_valid, store_commit_index,
    input  store_commit_ready,
    output redirect_en, redirect_pc, bp_update_en, bp_update_pc, bp_update_taken,
    output flush_out, count
`ifdef ROB_OPERAND_QUERY_EN
    , input q_index, output q_ready, q_data
`endif
  );

  modport master (
    output alloc_valid, alloc_type, alloc_rd, alloc_pc, alloc_pred_taken, alloc_alt_pc,
    input  alloc_ready, alloc_index,
    output cdb_valid, cdb_index, cdb_data,
    input  commit_valid, commit_rd, commit_index, commit_data,
    input  store_commit_valid, store_commit_index,
    output store_commit_ready,
    input  redirect_en, redirect_pc, bp_update_en, bp_update_pc, bp_update_taken,
    input  flush_out, count
`ifdef ROB_OPERAND_QUERY_EN
    , output q_index, input q_ready, q_data
`endif
  );
endinterface

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order allocate, multi-port CDB write-back, up to COMMIT_WIDTH
// in-order retirements per cycle. Define ROB_OPERAND_QUERY_EN for operand query ports.
module rob_multi_commit #(
  parameter int ROB_WIDTH    = 3,
  parameter int COMMIT_WIDTH = 2,
  parameter int CDB_PORTS    = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  rob_multi_commit_if.slave bus
);
  localparam int DEPTH = 1 << ROB_WIDTH;

  typedef logic [ROB_WIDTH-1:0] idx_t;
  typedef logic [ROB_WIDTH:0]   cnt_t;

  typedef enum logic [2:0] {
    TYPE_REG    = 3'd0,
    TYPE_BRANCH = 3'd1,
    TYPE_JALR   = 3'd2,
    TYPE_STORE  = 3'd3
  } entry_type_e;

  logic        busy_q   [DEPTH];
  logic        ready_q  [DEPTH];
  entry_type_e type_q   [DEPTH];
  logic [4:0]  rd_q     [DEPTH];
  logic [31:0] pc_q     [DEPTH];
  logic        pred_q   [DEPTH];
  logic [31:0] alt_pc_q [DEPTH];
  logic [31:0] data_q   [DEPTH];

  idx_t head_q;
  idx_t tail_q;
  cnt_t count_q;

  logic alloc_ready;
  logic alloc_fire;

  logic retire_slot [COMMIT_WIDTH];
  idx_t slot_idx    [COMMIT_WIDTH];
  cnt_t num_retire;
  logic scan_stop;
  logic branch_retire;
  logic jalr_retire;
  logic mispredict;
  idx_t ctrl_idx;

  assign alloc_ready     = count_q < cnt_t'(DEPTH);
  assign alloc_fire      = rdy_in && bus.alloc_valid && alloc_ready;
  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_index = tail_q;
  assign bus.count       = count_q;

  assign bus.store_commit_index = head_q;
  assign bus.store_commit_valid = rdy_in && busy_q[head_q] && ready_q[head_q] &&
                                  (type_q[head_q] == TYPE_STORE);

  // Commit scan over registered state only, so a CDB result is never retired on the edge that delivers it.
  always_comb begin
    num_retire    = '0;
    scan_stop     = !rdy_in;
    branch_retire = 1'b0;
    jalr_retire   = 1'b0;
    mispredict    = 1'b0;
    ctrl_idx      = head_q;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      slot_idx[k]    = head_q + idx_t'(k);
      retire_slot[k] = 1'b0;
      if (!scan_stop) begin
        if (busy_q[slot_idx[k]] && ready_q[slot_idx[k]]) begin
          case (type_q[slot_idx[k]])
            TYPE_STORE: begin
              if (k == 0 && bus.store_commit_ready) retire_slot[k] = 1'b1;
              else                                  scan_stop      = 1'b1;
            end
            TYPE_BRANCH: begin
              retire_slot[k] = 1'b1;
              scan_stop      = 1'b1;
              branch_retire  = 1'b1;
              ctrl_idx       = slot_idx[k];
              mispredict     = data_q[slot_idx[k]][0] != pred_q[slot_idx[k]];
            end
            TYPE_JALR: begin
              retire_slot[k] = 1'b1;
              scan_stop      = 1'b1;
              jalr_retire    = 1'b1;
              ctrl_idx       = slot_idx[k];
            end
            default: retire_slot[k] = 1'b1;
          endcase
        end else begin
          scan_stop = 1'b1;
        end
      end
      if (retire_slot[k]) num_retire = num_retire + cnt_t'(1);
    end
  end

  // Entry state: later statements override earlier ones, giving retire priority over a stale CDB write.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
      end
    end else if (rdy_in) begin
      if (mispredict) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          busy_q[i]  <= 1'b0;
          ready_q[i] <= 1'b0;
        end
      end else begin
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (bus.cdb_valid[p] && busy_q[bus.cdb_index[p*ROB_WIDTH +: ROB_WIDTH]]) begin
            ready_q[bus.cdb_index[p*ROB_WIDTH +: ROB_WIDTH]] <= 1'b1;
            data_q[bus.cdb_index[p*ROB_WIDTH +: ROB_WIDTH]]  <= bus.cdb_data[p*32 +: 32];
          end
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
          if (retire_slot[k]) begin
            busy_q[slot_idx[k]]  <= 1'b0;
            ready_q[slot_idx[k]] <= 1'b0;
          end
        end
        if (alloc_fire) begin
          busy_q[tail_q]   <= 1'b1;
          ready_q[tail_q]  <= 1'b0;
          type_q[tail_q]   <= entry_type_e'(bus.alloc_type);
          rd_q[tail_q]     <= bus.alloc_rd;
          pc_q[tail_q]     <= bus.alloc_pc;
          pred_q[tail_q]   <= bus.alloc_pred_taken;
          alt_pc_q[tail_q] <= bus.alloc_alt_pc;
          data_q[tail_q]   <= '0;
          tail_q           <= tail_q + idx_t'(1);
        end
        head_q  <= head_q + idx_t'(num_retire);
        count_q <= count_q + (alloc_fire ? cnt_t'(1) : cnt_t'(0)) - num_retire;
      end
    end
  end

  // Registered retirement, predictor and redirect outputs; pulses drop while stalled, data holds.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.commit_valid    <= '0;
      bus.commit_rd       <= '0;
      bus.commit_index    <= '0;
      bus.commit_data     <= '0;
      bus.redirect_en     <= 1'b0;
      bus.redirect_pc     <= '0;
      bus.bp_update_en    <= 1'b0;
      bus.bp_update_pc    <= '0;
      bus.bp_update_taken <= 1'b0;
      bus.flush_out       <= 1'b0;
    end else if (!rdy_in) begin
      bus.commit_valid <= '0;
      bus.redirect_en  <= 1'b0;
      bus.bp_update_en <= 1'b0;
      bus.flush_out    <= 1'b0;
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (retire_slot[k]) begin
          bus.commit_valid[k] <= ((type_q[slot_idx[k]] == TYPE_REG) ||
                                  (type_q[slot_idx[k]] == TYPE_JALR)) &&
                                 (rd_q[slot_idx[k]] != 5'd0);
          bus.commit_rd[k*5 +: 5]                    <= rd_q[slot_idx[k]];
          bus.commit_index[k*ROB_WIDTH +: ROB_WIDTH] <= slot_idx[k];
          bus.commit_data[k*32 +: 32] <= (type_q[slot_idx[k]] == TYPE_JALR) ?
                                         pc_q[slot_idx[k]] + 32'd4 : data_q[slot_idx[k]];
        end else begin
          bus.commit_valid[k]                        <= 1'b0;
          bus.commit_rd[k*5 +: 5]                    <= '0;
          bus.commit_index[k*ROB_WIDTH +: ROB_WIDTH] <= '0;
          bus.commit_data[k*32 +: 32]                <= '0;
        end
      end
      bus.bp_update_en <= branch_retire;
      if (branch_retire) begin
        bus.bp_update_pc    <= pc_q[ctrl_idx];
        bus.bp_update_taken <= data_q[ctrl_idx][0];
      end
      bus.redirect_en <= mispredict || jalr_retire;
      if (mispredict)       bus.redirect_pc <= alt_pc_q[ctrl_idx];
      else if (jalr_retire) bus.redirect_pc <= data_q[ctrl_idx] & ~32'h1;
      bus.flush_out <= mispredict;
    end
  end

`ifdef ROB_OPERAND_QUERY_EN
  // Operand lookup with same-cycle CDB forwarding; the highest matching port wins.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      bus.q_ready[q] = ready_q[bus.q_index[q]];
      bus.q_data[q]  = data_q[bus.q_index[q]];
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (bus.cdb_valid[p] && (bus.cdb_index[p*ROB_WIDTH +: ROB_WIDTH] == bus.q_index[q])) begin
          bus.q_ready[q] = 1'b1;
          bus.q_data[q]  = bus.cdb_data[p*32 +: 32];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed self-checking bench for rob_multi_commit with hand-computed expectations.
module tb_rob_multi_commit;
  localparam int ROB_WIDTH    = 3;
  localparam int COMMIT_WIDTH = 2;
  localparam int CDB_PORTS    = 2;

  localparam logic [2:0] T_REG    = 3'd0;
  localparam logic [2:0] T_BRANCH = 3'd1;
  localparam logic [2:0] T_JALR   = 3'd2;
  localparam logic [2:0] T_STORE  = 3'd3;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  int   checks = 0;
  int   errors = 0;

  rob_multi_commit_if #(.ROB_WIDTH(ROB_WIDTH), .COMMIT_WIDTH(COMMIT_WIDTH), .CDB_PORTS(CDB_PORTS)) bus ();

  rob_multi_commit #(.ROB_WIDTH(ROB_WIDTH), .COMMIT_WIDTH(COMMIT_WIDTH), .CDB_PORTS(CDB_PORTS)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance the given number of rising edges and settle just after the last one.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk_in);
    #1;
  endtask

  task automatic clearInputs();
    bus.alloc_valid        = 1'b0;
    bus.alloc_type         = '0;
    bus.alloc_rd           = '0;
    bus.alloc_pc           = '0;
    bus.alloc_pred_taken   = 1'b0;
    bus.alloc_alt_pc       = '0;
    bus.cdb_valid          = '0;
    bus.cdb_index          = '0;
    bus.cdb_data           = '0;
    bus.store_commit_ready = 1'b0;
  endtask

  task automatic setAlloc(input logic [2:0] t, input logic [4:0] rd, input logic [31:0] pc,
                          input logic pred, input logic [31:0] alt);
    bus.alloc_valid      = 1'b1;
    bus.alloc_type       = t;
    bus.alloc_rd         = rd;
    bus.alloc_pc         = pc;
    bus.alloc_pred_taken = pred;
    bus.alloc_alt_pc     = alt;
  endtask

  task automatic setCdb(input int port, input logic [ROB_WIDTH-1:0] idx, input logic [31:0] data);
    bus.cdb_valid[port]                        = 1'b1;
    bus.cdb_index[port*ROB_WIDTH +: ROB_WIDTH] = idx;
    bus.cdb_data[port*32 +: 32]                = data;
  endtask

  function automatic logic [4:0] rdOf(input int j);
    return (j == 4) ? 5'd0 : 5'(12 + j);
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    applyStimulus(2);
    rst_in = 1'b0;

    checkOutput("rst_count", bus.count, 0);
    checkOutput("rst_alloc_ready", bus.alloc_ready, 1);
    checkOutput("rst_alloc_index", bus.alloc_index, 0);
    checkOutput("rst_store_valid", bus.store_commit_valid, 0);
    checkOutput("rst_commit_valid", bus.commit_valid, 0);
    checkOutput("rst_commit_data", bus.commit_data, 0);
    checkOutput("rst_flush", bus.flush_out, 0);
    checkOutput("rst_redirect_en", bus.redirect_en, 0);
    checkOutput("rst_redirect_pc", bus.redirect_pc, 0);
    checkOutput("rst_bp_update_en", bus.bp_update_en, 0);

    // Fill all eight entries, then a refused ninth request.
    for (int i = 0; i < 8; i++) begin
      setAlloc(T_REG, 5'(i + 1), 32'h1000 + 32'(4 * i), 1'b0, 32'h0);
      checkOutput("fill_alloc_index", bus.alloc_index, i);
      applyStimulus(1);
    end
    checkOutput("full_count", bus.count, 8);
    checkOutput("full_alloc_ready", bus.alloc_ready, 0);
    setAlloc(T_REG, 5'd9, 32'h1020, 1'b0, 32'h0);
    applyStimulus(1);
    checkOutput("ninth_count", bus.count, 8);
    checkOutput("ninth_alloc_index", bus.alloc_index, 0);

    // Ports 1 and 0 fill entries 1 and 0; both retire on the following edge.
    clearInputs();
    setCdb(1, 3'd1, 32'hB1);
    setCdb(0, 3'd0, 32'hA0);
    applyStimulus(1);
    checkOutput("cdb_edge_commit_valid", bus.commit_valid, 0);
    checkOutput("cdb_edge_count", bus.count, 8);
    clearInputs();
    setAlloc(T_REG, 5'd30, 32'h0, 1'b0, 32'h0);
    applyStimulus(1);
    checkOutput("dual_commit_valid", bus.commit_valid, 2'b11);
    checkOutput("dual_commit_index", bus.commit_index, 6'o10);
    checkOutput("dual_commit_rd", bus.commit_rd, {5'd2, 5'd1});
    checkOutput("dual_commit_data", bus.commit_data, {32'hB1, 32'hA0});
    checkOutput("dual_count_full_refused", bus.count, 6);
    checkOutput("dual_alloc_index", bus.alloc_index, 0);
    clearInputs();
    applyStimulus(1);
    checkOutput("idle_commit_valid", bus.commit_valid, 0);
    checkOutput("idle_count", bus.count, 6);

    // Both ports name entry 2: port 1 wins.
    setCdb(0, 3'd2, 32'h22);
    setCdb(1, 3'd2, 32'h33);
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);
    checkOutput("prio_commit_valid", bus.commit_valid, 2'b01);
    checkOutput("prio_commit_data", bus.commit_data[31:0], 32'h33);
    checkOutput("prio_commit_index", bus.commit_index[2:0], 2);
    checkOutput("prio_count", bus.count, 5);

    // Stall with a ready head for two cycles.
    setCdb(0, 3'd3, 32'h44);
    applyStimulus(1);
    clearInputs();
    rdy_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1);
      checkOutput("stall_commit_valid", bus.commit_valid, 0);
      checkOutput("stall_count", bus.count, 5);
      checkOutput("stall_alloc_ready", bus.alloc_ready, 1);
    end
    rdy_in = 1'b1;
    applyStimulus(1);
    checkOutput("resume_commit_valid", bus.commit_valid, 2'b01);
    checkOutput("resume_commit_data", bus.commit_data[31:0], 32'h44);
    checkOutput("resume_count", bus.count, 4);

    // Drain entries 4..7.
    setCdb(0, 3'd4, 32'h55);
    setCdb(1, 3'd5, 32'h66);
    applyStimulus(1);
    clearInputs();
    setCdb(0, 3'd6, 32'h77);
    setCdb(1, 3'd7, 32'h88);
    applyStimulus(1);
    checkOutput("drain1_commit_valid", bus.commit_valid, 2'b11);
    checkOutput("drain1_commit_index", bus.commit_index, {3'd5, 3'd4});
    checkOutput("drain1_commit_data", bus.commit_data, {32'h66, 32'h55});
    checkOutput("drain1_count", bus.count, 2);
    clearInputs();
    applyStimulus(1);
    checkOutput("drain2_commit_valid", bus.commit_valid, 2'b11);
    checkOutput("drain2_commit_index", bus.commit_index, {3'd7, 3'd6});
    checkOutput("drain2_commit_data", bus.commit_data, {32'h88, 32'h77});
    checkOutput("drain2_count", bus.count, 0);

    // Store at head waits for the LSB.
    setAlloc(T_STORE, 5'd0, 32'h2000, 1'b0, 32'h0);
    applyStimulus(1);
    setAlloc(T_REG, 5'd9, 32'h2004, 1'b0, 32'h0);
    applyStimulus(1);
    clearInputs();
    setCdb(0, 3'd0, 32'hDEAD);
    applyStimulus(1);
    clearInputs();
    for (int i = 0; i < 3; i++) begin
      checkOutput("store_wait_valid", bus.store_commit_valid, 1);
      checkOutput("store_wait_index", bus.store_commit_index, 0);
      applyStimulus(1);
      checkOutput("store_wait_count", bus.count, 2);
      checkOutput("store_wait_commit_valid", bus.commit_valid, 0);
    end
    bus.store_commit_ready = 1'b1;
    checkOutput("store_go_valid", bus.store_commit_valid, 1);
    applyStimulus(1);
    bus.store_commit_ready = 1'b0;
    checkOutput("store_done_count", bus.count, 1);
    checkOutput("store_done_commit_valid", bus.commit_valid, 0);
    checkOutput("store_done_store_valid", bus.store_commit_valid, 0);
    setCdb(0, 3'd1, 32'h99);
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);
    checkOutput("after_store_commit_valid", bus.commit_valid, 2'b01);
    checkOutput("after_store_commit_rd", bus.commit_rd[4:0], 9);
    checkOutput("after_store_commit_data", bus.commit_data[31:0], 32'h99);
    checkOutput("after_store_commit_index", bus.commit_index[2:0], 1);
    checkOutput("after_store_count", bus.count, 0);

    // Mispredicted branch behind a REG entry; the same-edge allocation is dropped.
    setAlloc(T_REG, 5'd10, 32'h2ffc, 1'b0, 32'h0);
    applyStimulus(1);
    setAlloc(T_BRANCH, 5'd0, 32'h3000, 1'b0, 32'h100);
    applyStimulus(1);
    clearInputs();
    setCdb(0, 3'd2, 32'h1234);
    setCdb(1, 3'd3, 32'h1);
    applyStimulus(1);
    clearInputs();
    setAlloc(T_REG, 5'd11, 32'h3004, 1'b0, 32'h0);
    applyStimulus(1);
    clearInputs();
    checkOutput("mp_commit_valid", bus.commit_valid, 2'b01);
    checkOutput("mp_commit_data", bus.commit_data[31:0], 32'h1234);
    checkOutput("mp_bp_update_en", bus.bp_update_en, 1);
    checkOutput("mp_bp_update_pc", bus.bp_update_pc, 32'h3000);
    checkOutput("mp_bp_update_taken", bus.bp_update_taken, 1);
    checkOutput("mp_redirect_en", bus.redirect_en, 1);
    checkOutput("mp_redirect_pc", bus.redirect_pc, 32'h100);
    checkOutput("mp_flush", bus.flush_out, 1);
    checkOutput("mp_count", bus.count, 0);
    checkOutput("mp_alloc_index", bus.alloc_index, 0);
    applyStimulus(1);
    checkOutput("mp_after_flush", bus.flush_out, 0);
    checkOutput("mp_after_redirect_en", bus.redirect_en, 0);
    checkOutput("mp_after_bp_update_en", bus.bp_update_en, 0);
    checkOutput("mp_after_count", bus.count, 0);

    // Correctly predicted taken branch: update only.
    setAlloc(T_BRANCH, 5'd0, 32'h4000, 1'b1, 32'h200);
    applyStimulus(1);
    clearInputs();
    setCdb(0, 3'd0, 32'h1);
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);
    checkOutput("okbr_bp_update_en", bus.bp_update_en, 1);
    checkOutput("okbr_bp_update_pc", bus.bp_update_pc, 32'h4000);
    checkOutput("okbr_bp_update_taken", bus.bp_update_taken, 1);
    checkOutput("okbr_redirect_en", bus.redirect_en, 0);
    checkOutput("okbr_flush", bus.flush_out, 0);
    checkOutput("okbr_count", bus.count, 0);

    // JALR ends its group; the ready REG behind it retires next cycle.
    setAlloc(T_JALR, 5'd1, 32'h5000, 1'b0, 32'h0);
    applyStimulus(1);
    setAlloc(T_REG, 5'd2, 32'h5004, 1'b0, 32'h0);
    applyStimulus(1);
    clearInputs();
    setCdb(0, 3'd1, 32'h6001);
    setCdb(1, 3'd2, 32'h77);
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);
    checkOutput("jalr_commit_valid", bus.commit_valid, 2'b01);
    checkOutput("jalr_commit_data", bus.commit_data[31:0], 32'h5004);
    checkOutput("jalr_commit_rd", bus.commit_rd[4:0], 1);
    checkOutput("jalr_redirect_en", bus.redirect_en, 1);
    checkOutput("jalr_redirect_pc", bus.redirect_pc, 32'h6000);
    checkOutput("jalr_flush", bus.flush_out, 0);
    checkOutput("jalr_count", bus.count, 1);
    applyStimulus(1);
    checkOutput("jalr_next_commit_valid", bus.commit_valid, 2'b01);
    checkOutput("jalr_next_commit_index", bus.commit_index[2:0], 2);
    checkOutput("jalr_next_commit_data", bus.commit_data[31:0], 32'h77);
    checkOutput("jalr_next_redirect_en", bus.redirect_en, 0);
    checkOutput("jalr_next_count", bus.count, 0);

    // Streaming allocate/complete/retire across the 7 -> 0 wrap (tail starts at 3).
    for (int i = 0; i < 12; i++) begin
      int allocs;
      int retired;
      clearInputs();
      if (i < 10) setAlloc(T_REG, rdOf(i), 32'h6000 + 32'(4 * i), 1'b0, 32'h0);
      if (i >= 1 && i <= 10) setCdb(0, 3'((3 + i - 1) % 8), 32'h100 + 32'(i - 1));
      applyStimulus(1);
      allocs  = (i + 1 < 10) ? i + 1 : 10;
      retired = (i - 1 < 0) ? 0 : ((i - 1 > 10) ? 10 : i - 1);
      checkOutput("wrap_count", bus.count, allocs - retired);
      checkOutput("wrap_alloc_ready", bus.alloc_ready, 1);
      if (i >= 2) begin
        checkOutput("wrap_commit_valid", bus.commit_valid, {1'b0, rdOf(i - 2) != 5'd0});
        if (rdOf(i - 2) != 5'd0) begin
          checkOutput("wrap_commit_index", bus.commit_index[2:0], (3 + i - 2) % 8);
          checkOutput("wrap_commit_data", bus.commit_data[31:0], 32'h100 + 32'(i - 2));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
Parametrised next-generation reorder buffer sitting between the dispatcher, the CDB, the register file, the LSB and the fetch unit. It allocates one entry per cycle in program order and accepts results from several CDB ports per cycle. It retires up to COMMIT_WIDTH ready entries per cycle in order and handshakes store retirement with the LSB. On a branch mispredict or JALR it redirects fetch, and it flushes on a mispredict only.

Parameters:
ROB_WIDTH, 3, log2 of entry count; DEPTH = 1 << ROB_WIDTH
COMMIT_WIDTH, 2, maximum retirements per cycle (1..4)
CDB_PORTS, 2, number of result write-back ports

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; low = stall
alloc_valid  input  1  dispatcher requests an entry
alloc_ready  output  1  count < DEPTH (combinational from registered count)
alloc_index  output  ROB_WIDTH  tail index handed to the new entry
alloc_type  input  3  0 REG, 1 BRANCH, 2 JALR, 3 STORE
alloc_rd  input  5  destination register; 0 = no write
alloc_pc  input  32  instruction PC
alloc_pred_taken  input  1  predictor decision
alloc_alt_pc  input  32  PC to use if the prediction is wrong
cdb_valid  input  CDB_PORTS  per-port result valid
cdb_index  input  CDB_PORTS*ROB_WIDTH  packed entry indices
cdb_data  input  CDB_PORTS*32  packed results; BRANCH: bit0 = taken; JALR: target
commit_valid  output  COMMIT_WIDTH  per-slot RF write pulse
commit_rd  output  COMMIT_WIDTH*5  packed destinations
commit_index  output  COMMIT_WIDTH*ROB_WIDTH  packed retiring indices
commit_data  output  COMMIT_WIDTH*32  packed values (JALR: pc+4)
store_commit_valid  output  1  head store may write memory
store_commit_index  output  ROB_WIDTH  index of that store
store_commit_ready  input  1  LSB accepts the store this cycle
redirect_en  output  1  one-cycle fetch redirect pulse
redirect_pc  output  32  fetch target
bp_update_en  output  1  predictor update pulse
bp_update_pc  output  32  branch PC
bp_update_taken  output  1  actual outcome
flush_out  output  1  one-cycle pulse; all speculative state must be discarded
count  output  ROB_WIDTH+1  occupied entries

Behaviour:
- Reset: head = tail = count = 0; all busy and ready bits 0. Every pulse output is 0 and every data output is 0.
- rdy_in low: no state changes. Pulse outputs are driven 0 on the next edge. alloc_ready is still shown.
- Allocation: takes effect on the edge where alloc_valid && alloc_ready. The entry is written at tail, tail wraps mod DEPTH, and count increments. Allocation is refused when full, even if a commit happens on the same edge.
- CDB: each valid port sets ready and data of its entry. A write to a non-busy index is ignored. Two ports naming the same index: the higher port number wins.
- Commit scan over registered state, starting at head:
  - Take consecutive busy && ready entries, up to COMMIT_WIDTH.
  - Stop after a BRANCH or JALR entry, since it is the last entry in the group.
  - A STORE may only occupy slot 0 and retires only when store_commit_ready=1. Otherwise it blocks the scan.
  - An entry made ready by the CDB on edge N is eligible on edge N+1 at the earliest.
- Commit outputs are registered and valid the cycle after the retiring edge. Slot k corresponds to head+k. REG and JALR entries with rd=0 retire with commit_valid=0. head and count advance by the number retired; simultaneous alloc and retire adjust count by the net amount.
- store_commit_valid is combinational: high when the head entry is a busy, ready STORE and rdy_in=1.
- BRANCH retire: bp_update_en=1 with its pc and taken bit. If taken != pred_taken, the same edge also:
  - sets redirect_en=1, redirect_pc=alt_pc and flush_out=1;
  - clears all entries and sets head = tail = count = 0;
  - ignores any same-edge allocation and CDB writes.
- JALR retire: RF write of pc+4, plus redirect_en=1 with redirect_pc = data & ~1. No flush, because the dispatcher stalls after a JALR.
- Reset mid-operation overrides flush, allocation and commit.

Optional Feature:
ROB_OPERAND_QUERY_EN: when defined, the block adds two query ports for operand lookup.
- Each port has input q_index[ROB_WIDTH] and outputs q_ready[1] and q_data[32], all combinational.
- q_ready=1 if the entry is ready, or if a same-cycle CDB port carries that index; the CDB value is forwarded.
- When undefined, the ports do not exist and the dispatcher waits for the CDB broadcast.

Test Plan:
- Reset, then 8 allocations of REG entries rd=1..8 with no CDB -> alloc_index 0..7, count=8, alloc_ready=0; a 9th alloc_valid is ignored.
- CDB fills entries 1 and 0 on the same cycle through ports 1 and 0 -> the next cycle retires both; the following cycle shows commit_valid=2'b11 with indices 0 and 1.
- Head STORE ready with store_commit_ready=0 for 3 cycles -> no retirement and store_commit_valid=1 throughout; ready=1 -> it retires alone.
- BRANCH at head with pred_taken=0, CDB taken=1, alt_pc=0x100 -> bp_update_en=1, redirect_pc=0x100, flush_out=1, count=0; a same-edge allocation is dropped.
- Fill to wrap (tail 7 -> 0) while retiring -> order is preserved and count never exceeds 8.
- rdy_in low for 2 cycles with a ready head -> no commit; it resumes after rdy_in returns high.
